// File: rtl/module_cache_dm_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through cache.
package pkg_cache;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    WAIT_LOW
  } state_t;

  localparam int unsigned OFFSET_BITS   = 5;
  localparam int unsigned WORD_SEL_BITS = 3;

  function automatic int unsigned index_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_width,
                                           input int unsigned num_lines);
    return addr_width - OFFSET_BITS - index_bits(num_lines);
  endfunction

endpackage

// File: rtl/module_cache_dm_if.sv
// CPU-side and memory-side bus of module_cache_dm; slave is the cache's view.
interface module_cache_dm_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned SIZE_BLOCK = 256,
  parameter int unsigned WORD_SIZE  = 32
);
  logic                  cpu_rd_rq;
  logic                  cpu_wr_rq;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WORD_SIZE-1:0]  cpu_wr_data;
  logic [WORD_SIZE-1:0]  cpu_rd_data;
  logic                  cpu_ack;
  logic                  cpu_busy;
  logic                  rd_block_rq;
  logic [ADDR_WIDTH-1:0] rd_block_addr;
  logic                  rd_block_ack;
  logic [SIZE_BLOCK-1:0] rd_block_data;
  logic                  wr_bytes_rq;
  logic [ADDR_WIDTH-1:0] wr_bytes_addr;
  logic [WORD_SIZE-1:0]  wr_bytes_data;
  logic                  wr_bytes_ack;

  modport slave (
    input  cpu_rd_rq, cpu_wr_rq, cpu_addr, cpu_wr_data,
    output cpu_rd_data, cpu_ack, cpu_busy,
    output rd_block_rq, rd_block_addr,
    input  rd_block_ack, rd_block_data,
    output wr_bytes_rq, wr_bytes_addr, wr_bytes_data,
    input  wr_bytes_ack
  );

  modport master (
    output cpu_rd_rq, cpu_wr_rq, cpu_addr, cpu_wr_data,
    input  cpu_rd_data, cpu_ack, cpu_busy,
    input  rd_block_rq, rd_block_addr,
    output rd_block_ack, rd_block_data,
    input  wr_bytes_rq, wr_bytes_addr, wr_bytes_data,
    output wr_bytes_ack
  );
endinterface

// File: rtl/module_cache_dm_array.sv
// Valid/tag/data storage: combinational lookup, synchronous line fill or word update.
module module_cache_array
  import pkg_cache::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned SIZE_BLOCK = 256,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned NUM_LINES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:2] lk_addr,
  output logic                  lk_hit,
  output logic [WORD_SIZE-1:0]  lk_word,
  input  logic [ADDR_WIDTH-1:2] wr_addr,
  input  logic                  fill_en,
  input  logic [SIZE_BLOCK-1:0] fill_line,
  input  logic                  upd_en,
  input  logic [WORD_SIZE-1:0]  upd_word
);
  localparam int unsigned IDX = index_bits(NUM_LINES);
  localparam int unsigned TAG = tag_bits(ADDR_WIDTH, NUM_LINES);

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG-1:0]        tag_q  [NUM_LINES];
  logic [TAG-1:0]        tag_d  [NUM_LINES];
  logic [SIZE_BLOCK-1:0] data_q [NUM_LINES];
  logic [SIZE_BLOCK-1:0] data_d [NUM_LINES];

  logic [IDX-1:0]           lk_idx, wr_idx;
  logic [TAG-1:0]           lk_tag, wr_tag;
  logic [WORD_SEL_BITS-1:0] lk_ws, wr_ws;

  assign lk_idx = lk_addr[OFFSET_BITS +: IDX];
  assign lk_tag = lk_addr[ADDR_WIDTH-1 -: TAG];
  assign lk_ws  = lk_addr[OFFSET_BITS-1:2];
  assign wr_idx = wr_addr[OFFSET_BITS +: IDX];
  assign wr_tag = wr_addr[ADDR_WIDTH-1 -: TAG];
  assign wr_ws  = wr_addr[OFFSET_BITS-1:2];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_word = data_q[lk_idx][lk_ws*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = fill_line;
    end else if (upd_en) begin
      data_d[wr_idx][wr_ws*WORD_SIZE +: WORD_SIZE] = upd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/module_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module module_cache_dm
  import pkg_cache::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned SIZE_BLOCK = 256,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_STATS_EN
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
`endif
  module_cache_dm_if.slave bus
);
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic                    whit_q, whit_d;
  logic [WORD_SIZE-1:0]    rd_data_q, rd_data_d;
  logic                    ack_q, ack_d;
  logic                    rd_rq_q, rd_rq_d;
  logic                    wr_rq_q, wr_rq_d;
  logic [15:0]             hits_q, hits_d, misses_q, misses_d;

  logic                     lk_hit, fill_en, upd_en;
  logic [WORD_SIZE-1:0]     lk_word;
  logic [WORD_SEL_BITS-1:0] ws;
  logic                     unused_ok;

  assign ws        = addr_q[OFFSET_BITS-1:2];
  assign unused_ok = &{1'b0, bus.cpu_addr[1:0]};

  module_cache_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE_BLOCK (SIZE_BLOCK),
    .WORD_SIZE  (WORD_SIZE),
    .NUM_LINES  (NUM_LINES)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .lk_addr   (bus.cpu_addr[ADDR_WIDTH-1:2]),
    .lk_hit    (lk_hit),
    .lk_word   (lk_word),
    .wr_addr   (addr_q),
    .fill_en   (fill_en),
    .fill_line (bus.rd_block_data),
    .upd_en    (upd_en),
    .upd_word  (wdata_q)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    whit_d    = whit_q;
    rd_data_d = rd_data_q;
    ack_d     = 1'b0;
    rd_rq_d   = rd_rq_q;
    wr_rq_d   = wr_rq_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    fill_en   = 1'b0;
    upd_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read; the read is dropped, not queued.
        if (bus.cpu_wr_rq || bus.cpu_rd_rq) begin
          if (lk_hit) hits_d   = (hits_q == '1)   ? hits_q   : hits_q + 16'd1;
          else        misses_d = (misses_q == '1) ? misses_q : misses_q + 16'd1;
        end
        if (bus.cpu_wr_rq) begin
          state_d = WRITE;
          addr_d  = bus.cpu_addr[ADDR_WIDTH-1:2];
          wdata_d = bus.cpu_wr_data;
          whit_d  = lk_hit;
          wr_rq_d = 1'b1;
        end else if (bus.cpu_rd_rq) begin
          if (lk_hit) begin
            rd_data_d = lk_word;
            ack_d     = 1'b1;
          end else begin
            state_d = FILL;
            addr_d  = bus.cpu_addr[ADDR_WIDTH-1:2];
            rd_rq_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (bus.rd_block_ack) begin
          fill_en   = 1'b1;
          rd_data_d = bus.rd_block_data[ws*WORD_SIZE +: WORD_SIZE];
          ack_d     = 1'b1;
          rd_rq_d   = 1'b0;
          state_d   = WAIT_LOW;
        end
      end
      WRITE: begin
        if (bus.wr_bytes_ack) begin
          upd_en  = whit_q;
          ack_d   = 1'b1;
          wr_rq_d = 1'b0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.rd_block_ack && !bus.wr_bytes_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      whit_q    <= 1'b0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      rd_rq_q   <= 1'b0;
      wr_rq_q   <= 1'b0;
      hits_q    <= '0;
      misses_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      whit_q    <= whit_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      rd_rq_q   <= rd_rq_d;
      wr_rq_q   <= wr_rq_d;
      hits_q    <= hits_d;
      misses_q  <= misses_d;
    end
  end

  assign bus.cpu_rd_data   = rd_data_q;
  assign bus.cpu_ack       = ack_q;
  assign bus.cpu_busy      = (state_q != IDLE);
  assign bus.rd_block_rq   = rd_rq_q;
  assign bus.rd_block_addr = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign bus.wr_bytes_rq   = wr_rq_q;
  assign bus.wr_bytes_addr = {addr_q, 2'b00};
  assign bus.wr_bytes_data = wdata_q;

`ifdef CACHE_STATS_EN
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, hits_q, misses_q};
`endif
endmodule

// File: doc/module_cache_dm.md
Name: module_cache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller.
- Sits directly upstream of main memory and drives its block-read and word-write request/ack interfaces.
- Serves single-word CPU reads and writes; read hits complete in one cycle.
- Read misses fetch a full 256-bit line; every CPU write is forwarded to memory.

Parameters:
- ADDR_WIDTH, 16: byte address width.
- SIZE_BLOCK, 256: line size in bits (32 bytes, 8 words).
- WORD_SIZE, 32: CPU word width.
- NUM_LINES, 8: number of cache lines; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_rd_rq  in  1  read request, sampled only while cpu_busy=0.
- cpu_wr_rq  in  1  write request, sampled only while cpu_busy=0.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word-aligned).
- cpu_wr_data  in  WORD_SIZE  write data.
- cpu_rd_data  out  WORD_SIZE  read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever FSM is not IDLE.
- rd_block_rq  out  1  memory block-read request.
- rd_block_addr  out  ADDR_WIDTH  line-aligned address; low 5 bits are 0.
- rd_block_ack  in  1  memory read ack.
- rd_block_data  in  SIZE_BLOCK  line data; byte 0 in the LSBs.
- wr_bytes_rq  out  1  memory word-write request.
- wr_bytes_addr  out  ADDR_WIDTH  word-aligned byte address.
- wr_bytes_data  out  WORD_SIZE  write data.
- wr_bytes_ack  in  1  memory write ack.

Behaviour:
- Address split: offset = [4:0], word select = [4:2], index = [4+IDX:5] with IDX = log2(NUM_LINES), tag = the remaining upper bits. Defaults: index = [7:5], tag = [15:8].
- Word w of a line occupies line[32*w +: 32].
- Reset: all outputs 0, all valid bits cleared, FSM in IDLE. Reset mid-operation aborts immediately: requests drop, no partial line is marked valid.
- Memory handshake: the memory acks one cycle after it samples rq, and ack follows rq level. The controller holds rq, address and data stable until it sees ack=1. It then drops rq and waits in WAIT_LOW until ack=0 before returning to IDLE. The duplicate write the memory performs on the drop edge is idempotent and allowed.
- IDLE, request priority: if both requests are high, write wins and the read is ignored (not queued).
- IDLE, read hit: at the sampling edge, cpu_rd_data is registered and cpu_ack=1 for the next cycle. FSM stays IDLE, so back-to-back hits run at one per two cycles (ack cycle, then next sample).
- IDLE, read miss: go to FILL. Latch address; rd_block_rq=1 with line-aligned address.
- FILL: on rd_block_ack=1, write the line, set tag and valid, register the requested word, pulse cpu_ack, go to WAIT_LOW.
- IDLE, write: go to WRITE. wr_bytes_rq=1 with latched address and data.
- WRITE: on wr_bytes_ack=1, pulse cpu_ack. If the line was a hit at request time, update that word in the cache; a write miss allocates nothing. Go to WAIT_LOW.
- WAIT_LOW: all rq=0; on ack=0 go to IDLE.
- cpu_busy = (state != IDLE). Requests raised while busy are ignored.
- Eviction needs no write-back, since the cache is write-through.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs stat_hits [15:0] and stat_misses [15:0], saturating at 0xFFFF, cleared by rst. Counted per accepted read (hit or miss) and per accepted write (hit or miss).
- Undefined: these ports and counters do not exist.

Decomposition:
- Package pkg_cache holds:
  - state enum {IDLE, FILL, WRITE, WAIT_LOW};
  - OFFSET_BITS = 5, WORD_SEL_BITS = 3;
  - functions to compute INDEX_BITS and TAG_BITS from the parameters.
- Sub-module module_cache_array holds the valid/tag/data storage. It has a combinational lookup port (hit, word out) and a synchronous write port (full-line fill or single-word update).

Test Plan:
- Memory is initialised as mem[i] = i[7:0].
- Cold read miss: after reset, read 0x0004 -> rd_block_rq with rd_block_addr=0x0000; cpu_ack with cpu_rd_data=0x07060504; cpu_busy returns to 0 after ack drops.
- Read hit: read 0x0008 -> cpu_ack the next cycle with 0x0B0A0908; rd_block_rq stays 0.
- Write hit: write 0x0004 with 0xDEADBEEF -> wr_bytes_rq with addr 0x0004 and data 0xDEADBEEF; then read 0x0004 -> hit returning 0xDEADBEEF.
- Conflict eviction: read 0x0104 (index 0, tag 0x01) -> miss, fill from 0x0100, data 0x07060504. Then read 0x0004 -> miss, returns 0xDEADBEEF from memory.
- Write miss: write 0x0220 with 0x11223344 -> memory write only, no fill. Then read 0x0220 -> miss, returns 0x11223344.
- Reset mid-fill: assert rst while rd_block_rq=1 -> all outputs 0 immediately. Then read 0x0004 -> miss (valid bits were cleared).
